// File: rtl/pool_unit_pkg.sv
// Shared accelerator constants for the max-pool lane: default widths, buffer depth and latency.
package pool_unit_pkg;

    localparam int POOL_DATA_W      = 16;
    localparam int POOL_MAX_OUT_WID = 256;
    localparam int POOL_LAT         = 2;
    localparam int POOL_WIN_W       = 4;
    localparam int POOL_ROW_W       = 16;

    // A window size of zero behaves exactly like a window size of one.
    function automatic logic [POOL_WIN_W-1:0] pool_eff_win(input logic [POOL_WIN_W-1:0] w);
        return (w == '0) ? POOL_WIN_W'(1) : w;
    endfunction

endpackage

// File: rtl/pool_unit_row_mem.sv
// Partial-max row buffer: 1W/1R synchronous RAM with a registered read port.
// A read and a write to the same address in one cycle return the new data.
module pool_row_mem #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 256,
    parameter int AW     = 8
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [AW-1:0]     i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [AW-1:0]     i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= (i_we && (i_waddr == i_raddr)) ? i_wdata : r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/pool_unit.sv
// Streaming max-pool lane: horizontal max per sample, vertical max through a per-group row buffer.
// Partial reads are issued at h_cnt==0; for a window width of 1 the read is issued one sample
// early instead (next group on each close, group 0 on the last column), using the RAM's write-first bypass.
module pool_unit
    import pool_unit_pkg::*;
#(
    parameter int DATA_W      = POOL_DATA_W,
    parameter int MAX_OUT_WID = POOL_MAX_OUT_WID,
    parameter int LAT_POOL    = POOL_LAT
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_pool_enable,
    input  logic                     i_line_buffer_reset,
    input  logic                     i_shift_in,
    input  logic signed [DATA_W-1:0] i_data_in,
    input  logic [POOL_ROW_W-1:0]    i_row_length,
    input  logic [POOL_WIN_W-1:0]    i_pool_horiz,
    input  logic [POOL_WIN_W-1:0]    i_pool_vert,
    output logic signed [DATA_W-1:0] o_pool_out,
    output logic                     o_pool_out_valid,
    output logic                     o_cfg_err
);

    localparam int AW = (MAX_OUT_WID > 1) ? $clog2(MAX_OUT_WID) : 1;

    logic [POOL_WIN_W-1:0]    w_ph;
    logic [POOL_WIN_W-1:0]    w_pv;
    logic [POOL_ROW_W-1:0]    w_out_wid;
    logic [POOL_ROW_W-1:0]    w_used_cols;
    logic                     w_cfg_err;
    logic                     w_accept;
    logic                     w_last_col;
    logic                     w_in_body;
    logic                     w_h_last;
    logic                     w_v_last;
    logic                     w_close;
    logic                     w_emit;
    logic                     w_wr;
    logic                     w_rd_en;
    logic [AW-1:0]            w_rd_addr;
    logic [DATA_W-1:0]        w_rd_raw;
    logic signed [DATA_W-1:0] w_rd_data;
    logic signed [DATA_W-1:0] w_hmax_next;
    logic signed [DATA_W-1:0] w_comb;

    logic [POOL_ROW_W-1:0]    r_col;
    logic [POOL_WIN_W-1:0]    r_h;
    logic [POOL_WIN_W-1:0]    r_v;
    logic [AW-1:0]            r_grp;
    logic signed [DATA_W-1:0] r_hmax;
    logic [LAT_POOL-1:0]      r_pipe_v;
    logic signed [DATA_W-1:0] r_pipe_d [LAT_POOL];

    assign w_ph        = pool_eff_win(i_pool_horiz);
    assign w_pv        = pool_eff_win(i_pool_vert);
    assign w_out_wid   = i_row_length / POOL_ROW_W'(w_ph);
    assign w_used_cols = POOL_ROW_W'(w_out_wid * POOL_ROW_W'(w_ph));
    assign w_cfg_err   = (i_row_length == '0) || ({16'd0, w_out_wid} > 32'(MAX_OUT_WID));

    assign w_accept   = i_shift_in & i_pool_enable & ~i_line_buffer_reset & ~w_cfg_err;
    assign w_last_col = (r_col >= (i_row_length - POOL_ROW_W'(1)));
    assign w_in_body  = (r_col < w_used_cols);
    assign w_h_last   = (r_h >= (w_ph - POOL_WIN_W'(1)));
    assign w_v_last   = (r_v >= (w_pv - POOL_WIN_W'(1)));

    assign w_hmax_next = (r_h == '0) ? i_data_in :
                         ((i_data_in > r_hmax) ? i_data_in : r_hmax);
    assign w_rd_data   = w_rd_raw;
    assign w_comb      = (r_v == '0) ? w_hmax_next :
                         ((w_rd_data > w_hmax_next) ? w_rd_data : w_hmax_next);

    assign w_close = w_accept & w_in_body & w_h_last;
    assign w_emit  = w_close & w_v_last;
    assign w_wr    = w_close & ~w_v_last;

    assign w_rd_en   = w_accept & w_in_body & ((w_ph == POOL_WIN_W'(1)) | (r_h == '0));
    assign w_rd_addr = (w_ph == POOL_WIN_W'(1)) ? (w_last_col ? '0 : r_grp + AW'(1)) : r_grp;

    pool_row_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (MAX_OUT_WID),
        .AW     (AW)
    ) u_row_mem (
        .i_clk   (i_clk),
        .i_we    (w_wr),
        .i_waddr (r_grp),
        .i_wdata (w_comb),
        .i_re    (w_rd_en),
        .i_raddr (w_rd_addr),
        .o_rdata (w_rd_raw)
    );

    // Relational compares keep the counters wrapping even if the config moves under them.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_line_buffer_reset) begin
            r_col  <= '0;
            r_h    <= '0;
            r_v    <= '0;
            r_grp  <= '0;
            r_hmax <= '0;
        end else if (w_accept) begin
            if (w_last_col) begin
                r_col <= '0;
                r_h   <= '0;
                r_grp <= '0;
                r_v   <= w_v_last ? '0 : r_v + POOL_WIN_W'(1);
            end else begin
                r_col <= r_col + POOL_ROW_W'(1);
                if (w_in_body) begin
                    if (w_h_last) begin
                        r_h   <= '0;
                        r_grp <= r_grp + AW'(1);
                    end else begin
                        r_h <= r_h + POOL_WIN_W'(1);
                    end
                end
            end
            if (w_in_body) begin
                r_hmax <= w_hmax_next;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_pipe_v <= '0;
            for (int i = 0; i < LAT_POOL; i++) begin
                r_pipe_d[i] <= '0;
            end
        end else begin
            r_pipe_v[0] <= w_emit & ~i_line_buffer_reset;
            if (w_emit) begin
                r_pipe_d[0] <= w_comb;
            end
            for (int i = 1; i < LAT_POOL; i++) begin
                r_pipe_v[i] <= r_pipe_v[i-1] & ~i_line_buffer_reset;
                r_pipe_d[i] <= r_pipe_d[i-1];
            end
        end
    end

    assign o_pool_out       = r_pipe_d[LAT_POOL-1];
    assign o_pool_out_valid = r_pipe_v[LAT_POOL-1];
    assign o_cfg_err        = w_cfg_err;

endmodule

// File: tb/tb_pool_unit.sv
// Randomized bench for pool_unit: frames are scored against a whole-frame window-max model.
module tb_pool_unit;

    localparam int DATA_W      = 16;
    localparam int MAX_OUT_WID = 256;
    localparam int LAT         = 2;
    localparam int MAXS        = 8192;

    logic                     clk = 1'b0;
    logic                     rstN;
    logic                     poolEnable;
    logic                     lbr;
    logic                     shiftIn;
    logic signed [DATA_W-1:0] dataIn;
    logic [15:0]              rowLength;
    logic [3:0]               poolHoriz;
    logic [3:0]               poolVert;
    logic signed [DATA_W-1:0] poolOut;
    logic                     poolOutValid;
    logic                     cfgErr;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int frame [MAXS];
    int accCycle [MAXS];
    int expVal [$];
    int expIdx [$];
    int obsVal [$];
    int outCount = 0;

    always #5 clk = ~clk;

    pool_unit #(
        .DATA_W      (DATA_W),
        .MAX_OUT_WID (MAX_OUT_WID),
        .LAT_POOL    (LAT)
    ) dut (
        .i_clk               (clk),
        .i_rst_n             (rstN),
        .i_pool_enable       (poolEnable),
        .i_line_buffer_reset (lbr),
        .i_shift_in          (shiftIn),
        .i_data_in           (dataIn),
        .i_row_length        (rowLength),
        .i_pool_horiz        (poolHoriz),
        .i_pool_vert         (poolVert),
        .o_pool_out          (poolOut),
        .o_pool_out_valid    (poolOutValid),
        .o_cfg_err           (cfgErr)
    );

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Every valid pulse must match the oldest expected window, LAT cycles after its closing sample.
    always @(negedge clk) begin : monitor
        int v;
        int k;
        if (poolOutValid) begin
            outCount++;
            obsVal.push_back(int'(poolOut));
            if (expVal.size() == 0) begin
                checkOutput("spurious_valid", 1, 0);
            end else begin
                v = expVal.pop_front();
                k = expIdx.pop_front();
                checkOutput("pool_out", poolOut, v);
                checkOutput("latency", cyc - accCycle[k], LAT);
            end
        end
    end

    task automatic applyStimulus(input bit sh, input bit en, input bit lb, input int d);
        shiftIn    = sh;
        poolEnable = en;
        lbr        = lb;
        dataIn     = DATA_W'(d);
        @(posedge clk);
        #1;
    endtask

    task automatic fillFrame(input int n, input int mode);
        logic signed [DATA_W-1:0] t;
        for (int i = 0; i < n; i++) begin
            case (mode)
                1:       frame[i] = i;
                2:       frame[i] = int'($urandom_range(0, 8)) - 4;
                default: begin
                    t = DATA_W'($urandom);
                    frame[i] = int'(t);
                end
            endcase
        end
    endtask

    // Window maxima over the whole frame; trailing rows and remainder columns never appear.
    task automatic computeExpected(input int rl, input int ph, input int pv, input int nrows);
        int ow;
        int m;
        ow = rl / ph;
        for (int vg = 0; vg < nrows / pv; vg++) begin
            for (int g = 0; g < ow; g++) begin
                m = frame[vg * pv * rl + g * ph];
                for (int r = 0; r < pv; r++) begin
                    for (int c = 0; c < ph; c++) begin
                        if (frame[(vg * pv + r) * rl + g * ph + c] > m) begin
                            m = frame[(vg * pv + r) * rl + g * ph + c];
                        end
                    end
                end
                expVal.push_back(m);
                expIdx.push_back((vg * pv + pv - 1) * rl + g * ph + ph - 1);
            end
        end
    endtask

    task automatic runFrame(input int rl, input int phRaw, input int pvRaw, input int nrows,
                            input int gapMode);
        int  ph;
        int  pv;
        int  nExp;
        bit  cfgBad;
        bit  sh;
        ph = (phRaw == 0) ? 1 : phRaw;
        pv = (pvRaw == 0) ? 1 : pvRaw;
        rowLength = 16'(rl);
        poolHoriz = 4'(phRaw);
        poolVert  = 4'(pvRaw);
        applyStimulus(1, 1, 1, 12345);
        cfgBad = (rl == 0) || ((rl / ph) > MAX_OUT_WID);
        checkOutput("cfg_err", cfgErr, cfgBad);
        outCount = 0;
        obsVal.delete();
        if (!cfgBad) begin
            computeExpected(rl, ph, pv, nrows);
        end
        nExp = expVal.size();
        for (int idx = 0; idx < rl * nrows; idx++) begin
            if (gapMode == 1) begin
                applyStimulus(1, 0, 0, int'($urandom_range(0, 255)));
            end else if (gapMode == 2) begin
                repeat ($urandom_range(0, 2)) begin
                    sh = 1'($urandom_range(0, 1));
                    applyStimulus(sh, sh ? 1'b0 : 1'($urandom_range(0, 1)), 0,
                                  int'($urandom_range(0, 255)));
                end
            end
            accCycle[idx] = cyc;
            applyStimulus(1, 1, 0, frame[idx]);
        end
        repeat (LAT + 3) applyStimulus(0, 1, 0, 0);
        checkOutput("leftover_expected", expVal.size(), 0);
        checkOutput("out_count", outCount, nExp);
        expVal.delete();
        expIdx.delete();
    endtask

    // Drive a 2x2 frame up to its first emitting close, then kill it with reset or line reset.
    task automatic abortAfterClose(input bit useRst);
        fillFrame(8, 0);
        rowLength = 16'd4;
        poolHoriz = 4'd2;
        poolVert  = 4'd2;
        applyStimulus(0, 1, 1, 0);
        for (int idx = 0; idx < 6; idx++) begin
            accCycle[idx] = cyc;
            applyStimulus(1, 1, 0, frame[idx]);
        end
        if (useRst) begin
            rstN = 1'b0;
            applyStimulus(0, 1, 0, 0);
            applyStimulus(0, 1, 0, 0);
            checkOutput("rst_abort_out", poolOut, 0);
            checkOutput("rst_abort_valid", poolOutValid, 0);
            rstN = 1'b1;
        end else begin
            applyStimulus(0, 1, 1, 0);
            checkOutput("lbr_abort_valid", poolOutValid, 0);
        end
        repeat (4) applyStimulus(0, 1, 0, 0);
    endtask

    initial begin : watchdog
        #5000000;
        $display("[TB] FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int d035 [8];
        d035 = '{1, 5, -3, 2, 7, 0, 4, -8};
        rstN       = 1'b0;
        shiftIn    = 1'b0;
        poolEnable = 1'b0;
        lbr        = 1'b0;
        dataIn     = '0;
        rowLength  = 16'd4;
        poolHoriz  = 4'd2;
        poolVert   = 4'd2;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_out", poolOut, 0);
        checkOutput("reset_valid", poolOutValid, 0);
        rstN = 1'b1;
        applyStimulus(0, 0, 0, 0);
        checkOutput("reset_cfg_err", cfgErr, 0);

        $display("[TB] 2x2 directed frame");
        for (int i = 0; i < 8; i++) frame[i] = d035[i];
        runFrame(4, 2, 2, 2, 0);
        checkOutput("r035_count", obsVal.size(), 2);
        if (obsVal.size() >= 2) begin
            checkOutput("r035_first", obsVal[0], 7);
            checkOutput("r035_second", obsVal[1], 4);
        end

        $display("[TB] 3x3 ramp frame with remainder column");
        fillFrame(42, 1);
        runFrame(7, 3, 3, 6, 0);
        checkOutput("r036_count", outCount, 4);

        $display("[TB] 1x1 continuous");
        fillFrame(64, 0);
        runFrame(16, 1, 1, 4, 0);

        $display("[TB] 2x2 plain and with enable toggling");
        fillFrame(48, 0);
        runFrame(8, 2, 2, 6, 0);
        runFrame(8, 2, 2, 6, 1);

        $display("[TB] line reset and reset after a closing shift");
        abortAfterClose(1'b0);
        fillFrame(40, 2);
        runFrame(10, 2, 2, 4, 2);
        abortAfterClose(1'b1);
        fillFrame(40, 0);
        runFrame(10, 2, 2, 4, 0);

        $display("[TB] configuration limits");
        fillFrame(2048, 0);
        runFrame(1024, 2, 2, 2, 0);
        runFrame(0, 2, 2, 0, 0);
        fillFrame(1024, 0);
        runFrame(512, 2, 2, 2, 0);
        checkOutput("max_width_count", outCount, 256);

        $display("[TB] randomized frames");
        for (int it = 0; it < 30; it++) begin
            int rl;
            int nr;
            rl = int'($urandom_range(1, 40));
            nr = int'($urandom_range(1, 9));
            fillFrame(rl * nr, (it % 3 == 0) ? 2 : 0);
            runFrame(rl, int'($urandom_range(0, 5)), int'($urandom_range(0, 4)), nr,
                     int'($urandom_range(0, 2)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
